// File: rtl/msg_encoder.sv
// Command-message encoder: accepts one command (id + signed args) and streams
// it out as id byte followed by each argument VLQ-coded, on a show-ahead port.
module msg_encoder #(
   parameter int MAX_ARGS  = 8,
   parameter int ARGS_BITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [7:0]                cmd_id,
   input  logic [ARGS_BITS-1:0]      cmd_nargs,
   input  logic [32*MAX_ARGS-1:0]    cmd_args,
   output logic [7:0]                msg_data,
   output logic                      msg_ready,
   input  logic                      msg_rd_en,
   output logic                      frame_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMD,
      S_PREP,
      S_ARG
   } state_t;

   localparam logic [ARGS_BITS-1:0] MAX_N   = ARGS_BITS'(MAX_ARGS);
   localparam logic [ARGS_BITS-1:0] IDX_ONE = {{(ARGS_BITS-1){1'b0}}, 1'b1};

   // Signed ranges that fit in 1..4 bytes, given the decoder sign-fills only
   // when the two top payload bits of the first byte are both set.
   localparam logic signed [34:0] L1_LO = -35'sd32;
   localparam logic signed [34:0] L1_HI = 35'sd96;
   localparam logic signed [34:0] L2_LO = -35'sd4096;
   localparam logic signed [34:0] L2_HI = 35'sd12288;
   localparam logic signed [34:0] L3_LO = -35'sd524288;
   localparam logic signed [34:0] L3_HI = 35'sd1572864;
   localparam logic signed [34:0] L4_LO = -35'sd67108864;
   localparam logic signed [34:0] L4_HI = 35'sd201326592;

   state_t                  r_state;
   state_t                  w_next_state;

   logic [31:0]             r_args [MAX_ARGS];
   logic [ARGS_BITS-1:0]    r_left;
   logic [34:0]             r_shift;
   logic [2:0]              r_cnt;
   logic [7:0]              r_msg_data;
   logic                    r_msg_ready;

   logic                    w_pop;
   logic                    w_accept;
   logic [ARGS_BITS-1:0]    w_nargs_clamped;
   logic signed [34:0]      w_v35;
   logic [2:0]              w_len;
   logic [34:0]             w_aligned;

   assign w_pop           = msg_rd_en && r_msg_ready;
   assign w_accept        = cmd_valid && (r_state == S_IDLE);
   assign w_nargs_clamped = (cmd_nargs > MAX_N) ? MAX_N : cmd_nargs;

   assign msg_data  = r_msg_data;
   assign msg_ready = r_msg_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      cmd_ready    = 1'b0;
      frame_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_next_state = S_CMD;
            end
         end
         S_CMD: begin
            if (w_pop) begin
               if (r_left == '0) begin
                  w_next_state = S_IDLE;
                  frame_done   = 1'b1;
               end else begin
                  w_next_state = S_PREP;
               end
            end
         end
         S_PREP: begin
            w_next_state = S_ARG;
         end
         S_ARG: begin
            if (w_pop && (r_cnt == 3'd0)) begin
               if (r_left == '0) begin
                  w_next_state = S_IDLE;
                  frame_done   = 1'b1;
               end else begin
                  w_next_state = S_PREP;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Current argument is always r_args[0]; the bank shifts down once per arg.
   always_comb begin
      w_v35 = {{3{r_args[0][31]}}, r_args[0]};
      if (w_v35 >= L1_LO && w_v35 < L1_HI) begin
         w_len = 3'd1;
      end else if (w_v35 >= L2_LO && w_v35 < L2_HI) begin
         w_len = 3'd2;
      end else if (w_v35 >= L3_LO && w_v35 < L3_HI) begin
         w_len = 3'd3;
      end else if (w_v35 >= L4_LO && w_v35 < L4_HI) begin
         w_len = 3'd4;
      end else begin
         w_len = 3'd5;
      end

      // Left-align so the first emitted 7-bit group sits in bits [34:28].
      case (w_len)
         3'd1:    w_aligned = w_v35 << 28;
         3'd2:    w_aligned = w_v35 << 21;
         3'd3:    w_aligned = w_v35 << 14;
         3'd4:    w_aligned = w_v35 << 7;
         default: w_aligned = w_v35;
      endcase
   end

   // NOTE: the argument bank is pure data, only read after a load, so it
   // carries no reset and stays plain flops without a reset net.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < MAX_ARGS; i++) begin
            r_args[i] <= cmd_args[32*i +: 32];
         end
      end else if (r_state == S_PREP) begin
         for (int i = 0; i < MAX_ARGS - 1; i++) begin
            r_args[i] <= r_args[i+1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_left      <= '0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_msg_data  <= '0;
         r_msg_ready <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_msg_data  <= cmd_id;
                  r_msg_ready <= 1'b1;
                  r_left      <= w_nargs_clamped;
               end
            end
            S_CMD: begin
               if (w_pop) begin
                  r_msg_ready <= 1'b0;
               end
            end
            S_PREP: begin
               r_msg_data  <= {(w_len != 3'd1), w_aligned[34:28]};
               r_msg_ready <= 1'b1;
               r_shift     <= {w_aligned[27:0], 7'd0};
               r_cnt       <= w_len - 3'd1;
               r_left      <= r_left - IDX_ONE;
            end
            S_ARG: begin
               if (w_pop) begin
                  if (r_cnt != 3'd0) begin
                     r_msg_data <= {(r_cnt != 3'd1), r_shift[34:28]};
                     r_shift    <= {r_shift[27:0], 7'd0};
                     r_cnt      <= r_cnt - 3'd1;
                  end else begin
                     r_msg_ready <= 1'b0;
                  end
               end
            end
            default: begin
               r_msg_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msg_encoder.sv
// Directed + random bench for msg_encoder: expected bytes are queued when a
// command is driven and compared as the consumer pops them.
module tb_msg_encoder;

   localparam int MAX_ARGS  = 8;
   localparam int ARGS_BITS = 4;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [7:0]              cmd_id;
   logic [ARGS_BITS-1:0]    cmd_nargs;
   logic [32*MAX_ARGS-1:0]  cmd_args;
   logic [7:0]              msg_data;
   logic                    msg_ready;
   logic                    msg_rd_en;
   logic                    frame_done;

   int          errors = 0;
   int          checks = 0;
   int          last_cycles;
   byte unsigned exp_q[$];
   byte unsigned got_q[$];
   logic [31:0] arg_tab [MAX_ARGS];

   msg_encoder #(
      .MAX_ARGS  (MAX_ARGS),
      .ARGS_BITS (ARGS_BITS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_id     (cmd_id),
      .cmd_nargs  (cmd_nargs),
      .cmd_args   (cmd_args),
      .msg_data   (msg_data),
      .msg_ready  (msg_ready),
      .msg_rd_en  (msg_rd_en),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Shortest length whose decode (sign-fill iff top two payload bits set)
   // reproduces the value.
   function automatic int vlq_len(input logic [31:0] a);
      logic [63:0] v, mask, t, dec;
      v = {{32{a[31]}}, a};
      for (int l = 1; l <= 4; l++) begin
         mask = (64'd1 << (7*l)) - 64'd1;
         t    = v & mask;
         dec  = (t[7*l-1] && t[7*l-2]) ? (t | ~mask) : t;
         if (dec == v) return l;
      end
      return 5;
   endfunction

   task automatic push_model(input logic [7:0] id, input int n);
      int          nc, l;
      logic [63:0] v;
      logic [7:0]  b;
      exp_q.push_back(id);
      nc = (n > MAX_ARGS) ? MAX_ARGS : n;
      for (int a = 0; a < nc; a++) begin
         v = {{32{arg_tab[a][31]}}, arg_tab[a]};
         l = vlq_len(arg_tab[a]);
         for (int k = l - 1; k >= 0; k--) begin
            b = {(k != 0), 7'(v >> (7*k))};
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic send(input logic [7:0] id, input int n);
      @(negedge clk);
      check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_id    = id;
      cmd_nargs = ARGS_BITS'(n);
      for (int i = 0; i < MAX_ARGS; i++) cmd_args[32*i +: 32] = arg_tab[i];
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_id    = 8'hEE;
      check("first_byte_latency", 32'(msg_ready), 32'd1);
   endtask

   // Pops on every gap-th cycle; with junk set, msg_rd_en is also raised
   // whenever msg_ready is low.
   task automatic drain(input int gap, input bit junk);
      int   cyc;
      logic en;
      cyc = 0;
      got_q.delete();
      while (exp_q.size() > 0) begin
         if (cyc >= 2000) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            break;
         end
         en = msg_ready ? ((cyc % gap) == (gap - 1)) : junk;
         msg_rd_en = en;
         #1;
         check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
         if (msg_ready) begin
            check("msg_data", 32'(msg_data), 32'(exp_q[0]));
            check("frame_done", 32'(frame_done), 32'(en && exp_q.size() == 1));
            if (en) got_q.push_back(exp_q.pop_front());
         end else begin
            check("frame_done_gap", 32'(frame_done), 32'd0);
         end
         cyc++;
         @(negedge clk);
      end
      msg_rd_en   = 1'b0;
      last_cycles = cyc;
      #1;
      check("cmd_ready_after", 32'(cmd_ready), 32'd1);
      check("msg_ready_after", 32'(msg_ready), 32'd0);
   endtask

   function automatic logic [7:0] got_byte(input int i);
      return (i < got_q.size()) ? got_q[i] : 8'h00;
   endfunction

   // Parser-side rebuild of the popped stream.
   task automatic check_loopback(input logic [7:0] id, input int n);
      int          nc, idx;
      logic [7:0]  b;
      logic [63:0] v;
      nc  = (n > MAX_ARGS) ? MAX_ARGS : n;
      idx = 1;
      check("lb_id", 32'(got_byte(0)), 32'(id));
      for (int a = 0; a < nc; a++) begin
         b = got_byte(idx);
         idx++;
         v = (b[6:5] == 2'b11) ? '1 : '0;
         v = {v[56:0], b[6:0]};
         while (b[7] && idx < got_q.size()) begin
            b = got_byte(idx);
            idx++;
            v = {v[56:0], b[6:0]};
         end
         check("lb_arg", v[31:0], arg_tab[a]);
      end
      check("lb_len", 32'(got_q.size()), 32'(idx));
   endtask

   initial begin
      logic [7:0]         id;
      int                 n;
      logic signed [31:0] r;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_id    = 8'h00;
      cmd_nargs = '0;
      cmd_args  = '0;
      msg_rd_en = 1'b0;
      for (int i = 0; i < MAX_ARGS; i++) arg_tab[i] = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_msg_ready", 32'(msg_ready), 32'd0);
      check("rst_msg_data", 32'(msg_data), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      rst_n = 1'b1;

      // 1: id only
      send(8'h02, 0);
      exp_q = '{8'h02};
      drain(1, 1'b0);

      // 2: two small args, one PREP bubble per arg
      arg_tab[0] = 32'd5;
      arg_tab[1] = 32'hFFFF_FFFF;
      send(8'h0F, 2);
      exp_q = '{8'h0F, 8'h05, 8'h7F};
      drain(1, 1'b0);
      check("arg_bubble_cycles", 32'(last_cycles), 32'd5);
      check_loopback(8'h0F, 2);

      // 3: one/two byte boundaries
      arg_tab[0] = 32'h0000_005F;
      arg_tab[1] = 32'h0000_0060;
      arg_tab[2] = 32'hFFFF_FFE0;
      arg_tab[3] = 32'hFFFF_FFDF;
      send(8'h33, 4);
      exp_q = '{8'h33, 8'h5F, 8'h80, 8'h60, 8'h60, 8'hFF, 8'h5F};
      drain(1, 1'b0);
      check_loopback(8'h33, 4);

      // 4: five-byte values
      arg_tab[0] = 32'h1234_5678;
      arg_tab[1] = 32'h8000_0000;
      send(8'h44, 2);
      exp_q = '{8'h44, 8'h81, 8'h91, 8'hD1, 8'hAC, 8'h78,
                8'hF8, 8'h80, 8'h80, 8'h80, 8'h00};
      drain(1, 1'b0);
      check_loopback(8'h44, 2);

      // 5: slow consumer, spurious rd_en while not ready
      arg_tab[0] = 32'h0000_2FFF;
      arg_tab[1] = 32'hFFF8_0000;
      arg_tab[2] = 32'h0BFF_FFFF;
      arg_tab[3] = 32'h7FFF_FFFF;
      send(8'h55, 4);
      push_model(8'h55, 4);
      drain(3, 1'b1);
      check_loopback(8'h55, 4);

      // 6: reset mid-argument
      arg_tab[0] = 32'h1234_5678;
      send(8'h66, 1);
      msg_rd_en = 1'b1;
      repeat (3) @(negedge clk);
      msg_rd_en = 1'b0;
      #1;
      check("mid_arg_byte", 32'(msg_data), 32'h91);
      rst_n = 1'b0;
      #1;
      check("rst_mid_msg_ready", 32'(msg_ready), 32'd0);
      check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_mid_msg_data", 32'(msg_data), 32'd0);
      check("rst_mid_frame_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      arg_tab[0] = 32'hFFFF_F000;
      send(8'h67, 1);
      exp_q = '{8'h67, 8'hE0, 8'h00};
      drain(2, 1'b1);
      check_loopback(8'h67, 1);

      // 7: random loopback, including clamped nargs=9
      for (int t = 0; t < 24; t++) begin
         id = 8'($urandom);
         n  = (t == 0) ? 9 : int'($urandom_range(0, 9));
         for (int i = 0; i < MAX_ARGS; i++) begin
            r = $urandom;
            arg_tab[i] = r >>> $urandom_range(0, 31);
         end
         send(id, n);
         push_model(id, n);
         drain(int'($urandom_range(1, 3)), 1'b1);
         check_loopback(id, n);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
